// File: rtl/mddr_pkg.sv
// Shared types and command-decode helpers for the memory data register controller.
// Contents:
//   mddr_state_e : controller FSM states
//   is_load()    : write-decoder match (single select bit set, or all ones)
//   is_read()    : read-decoder match (single select bit set, or all ones)
package mddr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    RD_REQ  = 2'd2,
    RD_WAIT = 2'd3
  } mddr_state_e;

  localparam int unsigned SEL_MAX_W = 64;

  // One-hot-or-all-ones match over the low 'width' bits of a zero-extended select bus.
  function automatic logic sel_match(input logic [SEL_MAX_W-1:0] sel,
                                     input int unsigned bit_idx,
                                     input int unsigned width);
    logic [SEL_MAX_W-1:0] mask;
    logic [SEL_MAX_W-1:0] onehot;
    logic [SEL_MAX_W-1:0] masked;
    if (width >= SEL_MAX_W) mask = '1;
    else                    mask = (SEL_MAX_W'(1) << width) - SEL_MAX_W'(1);
    onehot = SEL_MAX_W'(1) << bit_idx;
    masked = sel & mask;
    return (masked == onehot) || (masked == mask);
  endfunction

  function automatic logic is_load(input logic [SEL_MAX_W-1:0] sel,
                                   input int unsigned bit_idx,
                                   input int unsigned width);
    return sel_match(sel, bit_idx, width);
  endfunction

  function automatic logic is_read(input logic [SEL_MAX_W-1:0] sel,
                                   input int unsigned bit_idx,
                                   input int unsigned width);
    return sel_match(sel, bit_idx, width);
  endfunction

endpackage

// File: rtl/mddr_wbuf.sv
// Posted-write buffer: synchronous FIFO with registered occupancy count.
// Ports:
//   clock, reset_n     : clock, async active-low reset (pointers/count only)
//   push, push_data    : write one entry (ignored when full)
//   pop                : retire head entry (ignored when empty)
//   full, empty, count : occupancy status
//   head               : oldest entry, valid while !empty
module mddr_wbuf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_data_reg_ctrl.sv
// Memory data register controller: posts decoder-selected loads into a write
// buffer drained to memory, and services reads after the buffer has drained
// (read-after-write ordering). Read data returns on a registered output.
// Optional build macro: MDDR_RD_TIMEOUT_EN (abort a read after RD_TIMEOUT wait cycles).
// Ports:
//   clock, reset_n               : clock, async active-low reset
//   wr_sel, rd_sel               : write/read decoder outputs
//   a_bus, addr_in               : command data and address
//   drop_clr                     : clears cmd_drop
//   core_data_out, rd_done, rd_err : read return to core (registered)
//   busy, cmd_drop, wbuf_count   : status (busy combinational)
//   mem_req/we/addr/wdata        : memory request (combinational)
//   mem_ready, mem_rvalid, mem_rdata : memory handshake / read return
module mem_data_reg_ctrl
  import mddr_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned SEL_W      = 20,
  parameter int unsigned LOAD_BIT   = 1,
  parameter int unsigned READ_BIT   = 0,
  parameter int unsigned WBUF_DEPTH = 4,
  parameter int unsigned RD_TIMEOUT = 64
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [SEL_W-1:0]                wr_sel,
  input  logic [SEL_W-2:0]                rd_sel,
  input  logic [DATA_W-1:0]               a_bus,
  input  logic [ADDR_W-1:0]               addr_in,
  input  logic                            drop_clr,
  output logic [DATA_W-1:0]               core_data_out,
  output logic                            rd_done,
  output logic                            rd_err,
  output logic                            busy,
  output logic                            cmd_drop,
  output logic [$clog2(WBUF_DEPTH+1)-1:0] wbuf_count,
  output logic                            mem_req,
  output logic                            mem_we,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  input  logic                            mem_ready,
  input  logic                            mem_rvalid,
  input  logic [DATA_W-1:0]               mem_rdata
);

  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  mddr_state_e       state;
  mddr_state_e       state_n;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_addr_n;
  logic [DATA_W-1:0] core_data_n;
  logic              rd_done_n;
  logic              rd_err_n;
  logic              cmd_drop_n;

  logic              load;
  logic              read;
  logic              read_acc;
  logic              drop;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [ENT_W-1:0]  head;
  logic              tmo_hit;

  // Command decode; a load always wins over a same-cycle read.
  assign load     = is_load(SEL_MAX_W'(wr_sel), LOAD_BIT, SEL_W);
  assign read     = is_read(SEL_MAX_W'(rd_sel), READ_BIT, SEL_W - 1);
  assign push     = load && !full;
  assign read_acc = read && !load && (state == IDLE);
  assign drop     = (load && full) || (read && !read_acc);
  assign busy     = (state != IDLE) || full;

  mddr_wbuf #(
    .WIDTH (ENT_W),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({addr_in, a_bus}),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .count     (wbuf_count),
    .head      (head)
  );

`ifdef MDDR_RD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(RD_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Counts completed RD_WAIT cycles; fires on the RD_TIMEOUT-th one.
  assign tmo_hit = (state == RD_WAIT) && (tmo_cnt == TMO_W'(RD_TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              tmo_cnt <= '0;
    else if (state != RD_WAIT) tmo_cnt <= '0;
    else                       tmo_cnt <= tmo_cnt + TMO_W'(1);
  end
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = ^(32'(RD_TIMEOUT));
`endif

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      rd_addr       <= '0;
      core_data_out <= '0;
      rd_done       <= 1'b0;
      rd_err        <= 1'b0;
      cmd_drop      <= 1'b0;
    end else begin
      state         <= state_n;
      rd_addr       <= rd_addr_n;
      core_data_out <= core_data_n;
      rd_done       <= rd_done_n;
      rd_err        <= rd_err_n;
      cmd_drop      <= cmd_drop_n;
    end
  end

  // Next state, memory request and next registered outputs.
  always_comb begin
    state_n     = state;
    rd_addr_n   = rd_addr;
    core_data_n = core_data_out;
    rd_done_n   = 1'b0;
    rd_err_n    = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    pop         = 1'b0;
    cmd_drop_n  = drop ? 1'b1 : (drop_clr ? 1'b0 : cmd_drop);

    case (state)
      IDLE, DRAIN: begin
        if (!empty) begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = head[ENT_W-1:DATA_W];
          mem_wdata = head[DATA_W-1:0];
          pop       = mem_ready;
        end
        if (state == IDLE) begin
          if (read_acc) begin
            rd_addr_n = addr_in;
            state_n   = DRAIN;
          end
        end else if (empty && !push) begin
          // A load arriving now is still drained before the read issues.
          state_n = RD_REQ;
        end
      end
      RD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = rd_addr;
        if (mem_ready) state_n = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          core_data_n = mem_rdata;
          rd_done_n   = 1'b1;
          state_n     = IDLE;
        end else if (tmo_hit) begin
          core_data_n = '0;
          rd_done_n   = 1'b1;
          rd_err_n    = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_data_reg_ctrl.sv
// Scoreboard bench for mem_data_reg_ctrl: stimulus pushes expected memory beats
// and read returns into queues; a negedge monitor pops and compares them.
module tb_mem_data_reg_ctrl;

  logic        clock;
  logic        reset_n;
  logic [19:0] wr_sel;
  logic [18:0] rd_sel;
  logic [15:0] a_bus;
  logic [15:0] addr_in;
  logic        drop_clr;
  logic [15:0] core_data_out;
  logic        rd_done;
  logic        rd_err;
  logic        busy;
  logic        cmd_drop;
  logic [2:0]  wbuf_count;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;

  mem_data_reg_ctrl dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .wr_sel        (wr_sel),
    .rd_sel        (rd_sel),
    .a_bus         (a_bus),
    .addr_in       (addr_in),
    .drop_clr      (drop_clr),
    .core_data_out (core_data_out),
    .rd_done       (rd_done),
    .rd_err        (rd_err),
    .busy          (busy),
    .cmd_drop      (cmd_drop),
    .wbuf_count    (wbuf_count),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } beat_t;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } ret_t;

  beat_t beat_q[$];
  ret_t  ret_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: every memory handshake and every rd_done pulse must match the queues.
  always @(negedge clock) begin
    if (reset_n) begin
      if (mem_req && mem_ready) begin
        if (beat_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL beat_unexpected: got we=%0d addr=0x%0h expected no beat", mem_we, mem_addr);
        end else begin
          beat_t e;
          e = beat_q.pop_front();
          chk("beat_we", 32'(mem_we), 32'(e.we));
          chk("beat_addr", 32'(mem_addr), 32'(e.addr));
          if (e.we) chk("beat_wdata", 32'(mem_wdata), 32'(e.data));
        end
      end
      if (rd_done) begin
        if (ret_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL rd_done_unexpected: got data=0x%0h expected no rd_done", core_data_out);
        end else begin
          ret_t r;
          r = ret_q.pop_front();
          chk("ret_data", 32'(core_data_out), 32'(r.data));
          chk("ret_err", 32'(rd_err), 32'(r.err));
        end
      end else if (rd_err) begin
        chk("rd_err_without_done", 32'(rd_err), 32'd0);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic load(input logic [19:0] sel, input logic [15:0] addr, input logic [15:0] data);
    wr_sel  = sel;
    addr_in = addr;
    a_bus   = data;
  endtask

  // Bounded wait for the read request to appear; returns with the request pending.
  task automatic wait_rd_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req && !mem_we) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("rd_req_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit ok;
    int n;
    reset_n = 1'b0; wr_sel = '0; rd_sel = '0; a_bus = '0; addr_in = '0;
    drop_clr = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #23;
    chk("rst_core_data", 32'(core_data_out), 32'd0);
    chk("rst_flags", 32'({rd_done, rd_err, busy, cmd_drop, mem_req}), 32'd0);
    chk("rst_count", 32'(wbuf_count), 32'd0);
    @(negedge clock); #1 reset_n = 1'b1;
    tick();

    // Load decode: single select bit, all ones, and a two-bit pattern.
    mem_ready = 1'b1;
    beat_q.push_back('{we: 1'b1, addr: 16'h0010, data: 16'h1234});
    load(20'h00002, 16'h0010, 16'h1234); tick(); wr_sel = '0; tick(3);
    beat_q.push_back('{we: 1'b1, addr: 16'h0010, data: 16'h1234});
    load(20'hFFFFF, 16'h0010, 16'h1234); tick(); wr_sel = '0; tick(3);
    load(20'h00006, 16'h0011, 16'h5678); tick(); wr_sel = '0;
    chk("no_push_count", 32'(wbuf_count), 32'd0);
    tick(3);

    // Fill buffer with memory stalled, overflow, then clear the drop flag.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat_q.push_back('{we: 1'b1, addr: 16'(16'h0100 + i), data: 16'(16'hA000 + i)});
      load(20'h00002, 16'(16'h0100 + i), 16'(16'hA000 + i)); tick();
    end
    chk("full_count", 32'(wbuf_count), 32'd4);
    chk("full_busy", 32'(busy), 32'd1);
    chk("full_nodrop", 32'(cmd_drop), 32'd0);
    load(20'h00002, 16'h0104, 16'hDEAD); tick(); wr_sel = '0;
    chk("ovf_drop", 32'(cmd_drop), 32'd1);
    chk("ovf_count", 32'(wbuf_count), 32'd4);
    drop_clr = 1'b1; tick(); drop_clr = 1'b0;
    chk("drop_clr", 32'(cmd_drop), 32'd0);
    mem_ready = 1'b1; tick(6);
    chk("drained_count", 32'(wbuf_count), 32'd0);

    // Read-after-write: write beat must precede the read request.
    beat_q.push_back('{we: 1'b1, addr: 16'h0020, data: 16'hBEEF});
    load(20'h00002, 16'h0020, 16'hBEEF); tick(); wr_sel = '0;
    beat_q.push_back('{we: 1'b0, addr: 16'h0020, data: 16'h0000});
    ret_q.push_back('{data: 16'hBEEF, err: 1'b0});
    rd_sel = 19'h00001; addr_in = 16'h0020; tick(); rd_sel = '0;
    wait_rd_req(ok);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 16'hBEEF; tick(); mem_rvalid = 1'b0;
    tick(3);
    chk("raw_core_data", 32'(core_data_out), 32'hBEEF);
    chk("raw_idle", 32'(busy), 32'd0);

    // Load and read in the same cycle: load wins, read dropped.
    mem_ready = 1'b0;
    beat_q.push_back('{we: 1'b1, addr: 16'h0040, data: 16'h0A0A});
    load(20'h00002, 16'h0040, 16'h0A0A); rd_sel = 19'h00001; tick();
    wr_sel = '0; rd_sel = '0;
    chk("coll_drop", 32'(cmd_drop), 32'd1);
    chk("coll_count", 32'(wbuf_count), 32'd1);
    chk("coll_not_busy", 32'(busy), 32'd0);
    mem_ready = 1'b1; drop_clr = 1'b1; tick(); drop_clr = 1'b0; tick(4);
    chk("coll_drained", 32'(wbuf_count), 32'd0);

    // Reset mid-RD_WAIT; a read outside IDLE is dropped first.
    beat_q.push_back('{we: 1'b0, addr: 16'h0030, data: 16'h0000});
    rd_sel = 19'h7FFFF; addr_in = 16'h0030; tick(); rd_sel = '0;
    wait_rd_req(ok);
    tick();
    rd_sel = 19'h00001; tick(); rd_sel = '0;
    chk("late_read_drop", 32'(cmd_drop), 32'd1);
    chk("rdwait_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_core_data", 32'(core_data_out), 32'd0);
    chk("mid_rst_flags", 32'({rd_done, rd_err, busy, cmd_drop, mem_req}), 32'd0);
    chk("mid_rst_count", 32'(wbuf_count), 32'd0);
    @(negedge clock); #1 reset_n = 1'b1;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 16'h5555; tick(3); mem_rvalid = 1'b0; tick(2);
    chk("stale_rvalid_data", 32'(core_data_out), 32'd0);
    chk("stale_rvalid_idle", 32'(busy), 32'd0);

`ifdef MDDR_RD_TIMEOUT_EN
    // Read never answered: abort on the 64th RD_WAIT cycle.
    beat_q.push_back('{we: 1'b0, addr: 16'h0050, data: 16'h0000});
    ret_q.push_back('{data: 16'h0000, err: 1'b1});
    rd_sel = 19'h00001; addr_in = 16'h0050; tick(); rd_sel = '0;
    wait_rd_req(ok);
    tick();
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (rd_done) begin
        n = i;
        break;
      end
    end
    chk("tmo_cycle", 32'(n), 32'd64);
    chk("tmo_err", 32'(rd_err), 32'd1);
    tick();
    chk("tmo_idle", 32'(busy), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 16'h7777; tick(); mem_rvalid = 1'b0; tick(2);
    chk("tmo_late_rvalid", 32'(core_data_out), 32'd0);
`else
    n = 0;
`endif

    chk("beat_q_empty", 32'(beat_q.size()), 32'd0);
    chk("ret_q_empty", 32'(ret_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
